// File: rtl/alu_unit_if.sv
// Operand/result bundle between the register file and alu_unit.
// start is a single-cycle request accepted on any rising edge where busy=0; done pulses once per accepted op.
interface alu_unit_if;
    logic        start;
    logic [3:0]  op;
    logic [15:0] r_bus;
    logic [15:0] s_bus;
    logic [3:0]  dst_addr;
    logic [3:0]  dst2_addr;
    logic        busy;
    logic        done;
    logic [15:0] reg3_bus;
    logic [3:0]  reg3_addr;
    logic        reg3_write;
    logic [15:0] reg4_bus;
    logic [3:0]  reg4_addr;
    logic        reg4_write;
    logic [3:0]  flags;

    modport master (
        output start, op, r_bus, s_bus, dst_addr, dst2_addr,
        input  busy, done, reg3_bus, reg3_addr, reg3_write,
               reg4_bus, reg4_addr, reg4_write, flags
    );

    modport slave (
        input  start, op, r_bus, s_bus, dst_addr, dst2_addr,
        output busy, done, reg3_bus, reg3_addr, reg3_write,
               reg4_bus, reg4_addr, reg4_write, flags
    );
endinterface

// File: rtl/alu_unit.sv
// 16-bit execution unit: single-cycle logic/arith/shift ops and 16-step
// iterative unsigned multiply/divide returning a second word on the reg4 path.
module alu_unit (
    input  logic       clk,
    input  logic       rst,
    alu_unit_if.slave  bus,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FINISH = 2'd2} state_e;

    state_e      state, state_nx;
    logic [3:0]  cnt_q, op_q, dst_q, dst2_q;
    logic [15:0] hi_q, lo_q, m_q;
    logic        iter_op;

    logic [16:0] sum17, shl17, shr17;
    logic [15:0] res;
    logic        res_c, res_v, res_wr, res_upd;
    logic [3:0]  simple_flags;

    logic [16:0] mul_sum, div_t;
    logic        div_ge;
    logic [15:0] div_d, hi_nx, lo_nx;
    logic [3:0]  fin_flags;

    logic        done_q, w3_q, w4_q;
    logic [15:0] b3_q, b4_q;
    logic [3:0]  a3_q, a4_q, flags_q;

    assign iter_op   = (bus.op == 4'd11) || (bus.op == 4'd12);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FINISH behaves like IDLE for acceptance, so a new op can start the cycle after done.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, FINISH: state_nx = (bus.start && iter_op) ? ITER : IDLE;
            ITER:         state_nx = (cnt_q == 4'd15) ? FINISH : ITER;
            default:      state_nx = IDLE;
        endcase
    end

    always_comb begin
        sum17   = '0;
        shl17   = '0;
        shr17   = '0;
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_wr  = 1'b1;
        res_upd = 1'b1;
        case (bus.op)
            4'd0: begin
                sum17 = {1'b0, bus.r_bus} + {1'b0, bus.s_bus};
                res   = sum17[15:0];
                res_c = sum17[16];
                res_v = (bus.r_bus[15] == bus.s_bus[15]) && (res[15] != bus.r_bus[15]);
            end
            4'd1, 4'd10: begin
                sum17  = {1'b0, bus.r_bus} - {1'b0, bus.s_bus};
                res    = sum17[15:0];
                res_c  = sum17[16];
                res_v  = (bus.r_bus[15] != bus.s_bus[15]) && (res[15] != bus.r_bus[15]);
                res_wr = (bus.op == 4'd1);
            end
            4'd2: res = bus.r_bus & bus.s_bus;
            4'd3: res = bus.r_bus | bus.s_bus;
            4'd4: res = bus.r_bus ^ bus.s_bus;
            4'd5: res = ~bus.r_bus;
            // Shifts run on a 17-bit window so the extra bit is the last bit shifted out.
            4'd6: begin
                shl17 = {1'b0, bus.r_bus} << bus.s_bus[3:0];
                res   = shl17[15:0];
                res_c = shl17[16];
            end
            4'd7: begin
                shr17 = {bus.r_bus, 1'b0} >> bus.s_bus[3:0];
                res   = shr17[16:1];
                res_c = shr17[0];
            end
            4'd8: begin
                shr17 = $signed({bus.r_bus, 1'b0}) >>> bus.s_bus[3:0];
                res   = shr17[16:1];
                res_c = shr17[0];
            end
            4'd9: res = bus.s_bus;
            default: begin
                res_wr  = 1'b0;
                res_upd = 1'b0;
            end
        endcase
        simple_flags = {res == 16'd0, res[15], res_c, res_v};
    end

    // hi_q holds the partial product / partial remainder, lo_q the multiplier / quotient.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : 17'd0);
        div_t   = {hi_q, lo_q[15]};
        div_ge  = div_t >= {1'b0, m_q};
        div_d   = div_ge ? 16'(div_t - {1'b0, m_q}) : div_t[15:0];
        if (op_q == 4'd11) begin
            hi_nx     = mul_sum[16:1];
            lo_nx     = {mul_sum[0], lo_q[15:1]};
            fin_flags = {{hi_nx, lo_nx} == 32'd0, hi_nx[15], hi_nx != 16'd0, hi_nx != 16'd0};
        end else begin
            hi_nx     = div_d;
            lo_nx     = {lo_q[14:0], div_ge};
            fin_flags = {lo_nx == 16'd0, 1'b0, 1'b0, m_q == 16'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0; op_q <= '0; dst_q <= '0; dst2_q <= '0;
            hi_q <= '0; lo_q <= '0; m_q <= '0;
            done_q <= 1'b0; w3_q <= 1'b0; w4_q <= 1'b0;
            b3_q <= '0; b4_q <= '0; a3_q <= '0; a4_q <= '0; flags_q <= '0;
        end else begin
            done_q <= 1'b0;
            w3_q   <= 1'b0;
            w4_q   <= 1'b0;
            if (state == ITER) begin
                hi_q  <= hi_nx;
                lo_q  <= lo_nx;
                cnt_q <= cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    done_q  <= 1'b1;
                    w3_q    <= 1'b1;
                    w4_q    <= 1'b1;
                    b3_q    <= lo_nx;
                    b4_q    <= hi_nx;
                    a3_q    <= dst_q;
                    a4_q    <= dst2_q;
                    flags_q <= fin_flags;
                end
            end else if (bus.start) begin
                op_q   <= bus.op;
                dst_q  <= bus.dst_addr;
                dst2_q <= bus.dst2_addr;
                if (iter_op) begin
                    hi_q  <= '0;
                    lo_q  <= bus.r_bus;
                    m_q   <= bus.s_bus;
                    cnt_q <= '0;
                end else begin
                    done_q <= 1'b1;
                    if (res_wr) begin
                        w3_q <= 1'b1;
                        b3_q <= res;
                        a3_q <= bus.dst_addr;
                    end
                    if (res_upd) flags_q <= simple_flags;
                end
            end
        end
    end

    assign bus.busy       = (state == ITER);
    assign bus.done       = done_q;
    assign bus.reg3_bus   = b3_q;
    assign bus.reg3_addr  = a3_q;
    assign bus.reg3_write = w3_q;
    assign bus.reg4_bus   = b4_q;
    assign bus.reg4_addr  = a4_q;
    assign bus.reg4_write = w4_q;
    assign bus.flags      = flags_q;
endmodule
